// File: rtl/ahb_pkg.sv
// ahb_pkg: shared encodings for the AHB-Lite master transaction engine
package ahb_pkg;
    typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_e;
    typedef enum logic [2:0] {
        OP_WR = 3'd0, OP_RD = 3'd1, OP_INCR4_WR = 3'd2,
        OP_WRAP4_WR = 3'd3, OP_INCR4_RD = 3'd4, OP_WRAP4_RD = 3'd5
    } op_e;
    localparam int BURST_LEN = 4;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_SEQ, S_LASTDATA} state_e;
endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: next word address for INCR or 16-byte WRAP bursts
module ahb_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wrap,
    output logic [ADDR_W-1:0] next_addr
);
    always_comb next_addr = wrap ? {addr[ADDR_W-1:4], addr[3:0] + 4'd4} : addr + ADDR_W'(4);
endmodule

// File: rtl/ahb_txn_master.sv
// ahb_txn_master: single/INCR4/WRAP4 AHB-Lite master with pipelined address and data phases
module ahb_txn_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WDATA_STEP = 1
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hr_readyout,
    input  logic [DATA_W-1:0] hr_data,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              hwrite,
    output logic              hready_in,
    output logic [1:0]        htrans,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done
);
    import ahb_pkg::*;
    state_e state;
    logic wrap, burst;
    logic [1:0] cnt;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] next_addr;
    ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (.addr(haddr), .wrap(wrap), .next_addr(next_addr));
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            htrans    <= TR_IDLE;
            haddr     <= '0;
            hwdata    <= '0;
            hwrite    <= 1'b0;
            hready_in <= 1'b0;
            cmd_ready <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            burst     <= 1'b0;
            cnt       <= '0;
            wd        <= '0;
        end else begin
            hready_in <= 1'b1;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            // a data phase is in flight in every state past the first address phase
            if ((state == S_SEQ || state == S_LASTDATA) && hr_readyout && !hwrite) begin
                rd_data  <= hr_data;
                rd_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready && cmd_op inside {OP_WR, OP_RD, OP_INCR4_WR, OP_WRAP4_WR, OP_INCR4_RD, OP_WRAP4_RD}) begin
                        state     <= S_ADDR;
                        cmd_ready <= 1'b0;
                        htrans    <= TR_NONSEQ;
                        haddr     <= cmd_addr & ~ADDR_W'(3);
                        hwrite    <= cmd_op inside {OP_WR, OP_INCR4_WR, OP_WRAP4_WR};
                        burst     <= !(cmd_op inside {OP_WR, OP_RD});
                        wrap      <= cmd_op inside {OP_WRAP4_WR, OP_WRAP4_RD};
                        wd        <= cmd_wdata;
                        cnt       <= '0;
                    end
                end
                S_ADDR, S_SEQ: if (hr_readyout) begin
                    if (hwrite) begin
                        hwdata <= wd;
                        wd     <= wd + DATA_W'(WDATA_STEP);
                    end
                    if (!burst || cnt == 2'(BURST_LEN - 1)) begin
                        htrans <= TR_IDLE;
                        state  <= S_LASTDATA;
                    end else begin
                        htrans <= TR_SEQ;
                        haddr  <= next_addr;
                        cnt    <= cnt + 2'd1;
                        state  <= S_SEQ;
                    end
                end
                default: if (hr_readyout) begin
                    state     <= S_IDLE;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_txn_master.sv
// tb_ahb_txn_master: randomized scoreboard bench with an address-sequence reference model and slave model
module tb_ahb_txn_master;
    localparam int STEP = 1;
    typedef struct {logic [31:0] a; logic [1:0] t; logic w;} aph_t;

    logic clk, hresetn, hr_readyout, cmd_valid, cmd_ready, rd_valid, done, hwrite, hready_in;
    logic [31:0] hr_data, haddr, hwdata, cmd_addr, cmd_wdata, rd_data;
    logic [1:0] htrans;
    logic [2:0] cmd_op;

    int n_chk = 0, n_fail = 0;
    int mode = 0, stall_left = 0;
    aph_t exp_addr[$];
    logic [31:0] exp_wd[$], exp_rd[$];
    int exp_done[$];
    logic dp_v, dp_w, up, prev_dp;
    logic [31:0] dp_a;

    ahb_txn_master #(.ADDR_W(32), .DATA_W(32), .WDATA_STEP(STEP)) dut (
        .hclk(clk), .hresetn(hresetn), .hr_readyout(hr_readyout), .hr_data(hr_data),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hready_in(hready_in), .htrans(htrans),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rdfun(input logic [31:0] a);
        return a == 32'h8000_0040 ? 32'hA5A5_0001 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not expected or not seen", nm);
    endtask

    // Slave view: which address owns the current data phase
    always @(posedge clk or negedge hresetn)
        if (!hresetn) begin
            dp_v <= 0; dp_a <= 0; dp_w <= 0; up <= 0;
        end else begin
            up <= 1;
            if (hr_readyout) begin
                dp_v <= htrans[1]; dp_a <= haddr; dp_w <= hwrite;
            end
        end
    assign hr_data = dp_v ? rdfun(dp_a) : 32'hDEAD_BEEF;

    initial begin
        hr_readyout = 1;
        forever begin
            @(posedge clk); #1;
            if (mode == 1) hr_readyout = $urandom_range(0, 3) != 0;
            else if (mode == 2 && stall_left > 0 && htrans == 2'b11 && haddr[3:0] == 4'h0) begin
                hr_readyout = 0;
                stall_left--;
            end else hr_readyout = 1;
        end
    end

    always @(negedge clk) begin
        if (!hresetn || !up) prev_dp = 0;
        else begin
            check("hready_in", hready_in, 1);
            check("no_busy", htrans == 2'b01, 0);
            if (rd_valid) begin
                check("rd_valid_timing", prev_dp, 1);
                if (exp_rd.size() == 0) fail("rd_unexpected");
                else check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (done) begin
                check("done_timing", prev_dp, 1);
                check("ready_at_done", cmd_ready, 1);
                if (exp_done.size() == 0) fail("done_unexpected");
                else begin
                    void'(exp_done.pop_front());
                    check("beats_left_at_done", exp_addr.size() + exp_wd.size() + exp_rd.size(), 0);
                end
            end
            if (htrans[1] && hr_readyout) begin
                if (exp_addr.size() == 0) fail("addr_phase_unexpected");
                else begin
                    aph_t e;
                    e = exp_addr.pop_front();
                    check("addr_phase", {haddr, htrans, hwrite}, {e.a, e.t, e.w});
                end
            end
            if (dp_v && hr_readyout && dp_w) begin
                if (exp_wd.size() == 0) fail("wdata_unexpected");
                else check("hwdata", hwdata, exp_wd.pop_front());
            end
            prev_dp = dp_v && hr_readyout;
        end
    end

    task automatic push_model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        logic wrap, wr;
        logic [31:0] a0, ai;
        if (op > 3'd5) return;
        n = op < 3'd2 ? 1 : 4;
        wrap = op == 3'd3 || op == 3'd5;
        wr = op == 3'd0 || op == 3'd2 || op == 3'd3;
        a0 = addr & ~32'h3;
        for (int i = 0; i < n; i++) begin
            ai = wrap ? ((a0 & ~32'hF) | ((a0 + 32'(4 * i)) & 32'hF)) : a0 + 32'(4 * i);
            exp_addr.push_back('{a: ai, t: (i == 0) ? 2'b10 : 2'b11, w: wr});
            if (wr) exp_wd.push_back(wd + 32'(i * STEP));
            else exp_rd.push_back(rdfun(ai));
        end
        exp_done.push_back(n);
    endtask

    task automatic flush;
        exp_addr.delete(); exp_wd.delete(); exp_rd.delete(); exp_done.delete();
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int t = 0;
        while (!cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) fail("cmd_ready_timeout");
        push_model(op, addr, wd);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int t = 0;
        issue(op, addr, wd);
        if (op > 3'd5) begin
            check("dropped_op_ready", cmd_ready, 1);
            repeat (4) begin @(posedge clk); #1; end
        end
        while (exp_done.size() > 0 && t < 300) begin @(posedge clk); #1; t++; end
        if (t >= 300) begin
            fail("done_timeout");
            flush();
        end
    endtask

    task automatic check_reset_vals;
        check("rst_htrans", htrans, 0);
        check("rst_haddr", haddr, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_flags", {hwrite, rd_valid, done, cmd_ready, hready_in}, 0);
    endtask

    initial begin
        int t;
        hresetn = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals();
        hresetn = 1;
        @(posedge clk); #1;
        check("ready_after_release", {cmd_ready, hready_in}, 2'b11);

        run_cmd(3'd0, 32'h8000_0000, 32'h11);
        run_cmd(3'd1, 32'h8000_0040, 32'h0);
        run_cmd(3'd2, 32'h8000_0004, 32'h20);
        run_cmd(3'd5, 32'h8000_0008, 32'h0);
        mode = 2; stall_left = 2;
        run_cmd(3'd3, 32'h8000_0008, 32'h40);
        check("stall_consumed", stall_left, 0);
        mode = 0;
        run_cmd(3'd6, 32'h8000_0100, 32'h1);
        run_cmd(3'd7, 32'h8000_0200, 32'h2);

        issue(3'd4, 32'h8000_0100, 32'h0);
        t = 0;
        while (htrans != 2'b11 && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) fail("seq_beat_timeout");
        @(posedge clk); #3;
        hresetn = 0;
        #1 check_reset_vals();
        flush();
        @(posedge clk); #1;
        hresetn = 1;
        @(posedge clk); #1;
        check("ready_after_abort", cmd_ready, 1);
        run_cmd(3'd1, 32'h8000_0040, 32'h0);

        mode = 1;
        for (int i = 0; i < 40; i++)
            run_cmd(3'($urandom_range(0, 7)),
                    ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 32'h3F0)) | 32'($urandom_range(0, 3)),
                    $urandom);
        mode = 0;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_txn_master.md
Name: ahb_txn_master

Overview:
- Synthesizable AHB-Lite master transaction engine that replaces a task-driven bus-functional master in front of the AHB-to-APB bridge.
- Accepts one command at a time: single write, single read, INCR4 write, WRAP4 write, INCR4 read or WRAP4 read.
- Drives the AHB address/control and write-data phases with correct pipelining, and returns read data.
- Word transfers only (HSIZE implied 32-bit); no HBURST/HSIZE/HRESP ports.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WDATA_STEP, 1, value added to write data for each successive burst beat.

Ports:
- hclk  in  1  clock, rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hr_readyout  in  1  slave HREADYOUT; low inserts wait states.
- hr_data  in  DATA_W  slave HRDATA.
- haddr  out  ADDR_W  HADDR.
- hwdata  out  DATA_W  HWDATA.
- hwrite  out  1  HWRITE.
- hready_in  out  1  HREADY driven to the slave.
- htrans  out  2  HTRANS: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- cmd_valid  in  1  command request.
- cmd_op  in  3  0 single write, 1 single read, 2 INCR4 write, 3 WRAP4 write, 4 INCR4 read, 5 WRAP4 read.
- cmd_addr  in  ADDR_W  start address; bits [1:0] forced to 0.
- cmd_wdata  in  DATA_W  first-beat write data.
- cmd_ready  out  1  high when idle; command accepted when cmd_valid & cmd_ready.
- rd_data  out  DATA_W  captured read data.
- rd_valid  out  1  one-cycle pulse per completed read beat.
- done  out  1  one-cycle pulse when the final data phase completes.

Behaviour:
- Reset (async, hresetn=0) forces:
  - htrans=IDLE; haddr, hwdata, rd_data = 0; hwrite, rd_valid, done, cmd_ready, hready_in = 0.
  - FSM to IDLE.
- From the first rising edge after reset release, hready_in=1 permanently and cmd_ready=1 in IDLE.
- Reset asserted mid-operation aborts immediately; no done pulse is generated.
- FSM states:
  - IDLE to ADDR on command accept. Ops 6/7 are accepted and dropped: stay IDLE, no bus activity, no done.
  - ADDR: beat 0 address phase.
  - SEQ: beats 1..3 address phases.
  - LASTDATA: final data phase only.
  - IDLE: return when the final data phase completes.
- Cycle after accept: htrans=NONSEQ, haddr=A0, hwrite=op is a write.
- An address phase advances only on a rising edge with hr_readyout=1. While hr_readyout=0, haddr, htrans, hwrite and hwdata hold unchanged.
- Pipelining: beat i's data phase is the cycle after its address phase is accepted.
  - Write data: hwdata = cmd_wdata + i*WDATA_STEP, presented during that data phase.
  - Read data: rd_data captures hr_data and rd_valid pulses at the edge where the data phase completes (hr_readyout=1).
- Bursts:
  - Beats 1..3 use htrans=SEQ, overlapping the previous beat's data phase.
  - After the 4th address phase is accepted, htrans=IDLE and haddr holds its last value.
- Singles: after the address phase is accepted, htrans=IDLE and the FSM goes to LASTDATA.
- Address generation:
  - INCR4: A(i+1) = A(i)+4; carry propagates across 1 KB boundaries, and the caller must avoid crossing them.
  - WRAP4: A(i+1) = {A[ADDR_W-1:4], A[3:0]+4 mod 16}, i.e. a 16-byte wrap.
- done pulses in the cycle after the last data phase completes; cmd_ready returns high in that same cycle.
- BUSY is never driven.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings.
  - cmd_op encodings.
  - Burst length constant 4.
  - FSM state typedef.
- One sub-module, ahb_addr_gen: combinational next-address from current address and INCR/WRAP mode.

Test Plan:
- Single write: op0, addr 0x8000_0000, wdata 0x11, hr_readyout=1.
  - NONSEQ/0x8000_0000/hwrite=1 for one cycle, then IDLE with hwdata=0x11.
  - done one cycle later.
- Single read: op1, addr 0x8000_0040, slave returns 0xA5A5_0001.
  - rd_valid pulses with rd_data=0xA5A5_0001, then done.
- INCR4 write: op2, addr 0x8000_0004, wdata 0x20.
  - haddr 04, 08, 0C, 10 with NONSEQ,SEQ,SEQ,SEQ.
  - hwdata 0x20..0x23, each lagging its address by one cycle.
- WRAP4 read: op5, addr 0x8000_0008, slave returns addr-based data.
  - haddr 08, 0C, 00, 04; four rd_valid pulses in order; done.
- Wait states: WRAP4 write from 0x8000_0008 with hr_readyout low 2 cycles on beat 2.
  - All outputs hold during the stall; sequence completes correctly.
- Reset mid INCR4 read after beat 1:
  - Outputs return to reset values immediately; no done.
  - cmd_ready=1 after release; a new op1 completes normally.
